// File: rtl/fifo_uart_tx.sv
// ---------------------------------------------------------------------------
// fifo_uart_tx
//
// Drain stage for a 16-deep, 8-bit fifo. Whenever transmission is enabled and
// the fifo holds data, one byte is popped and serialised on a single wire as
// an asynchronous frame: start bit (0), DATA_W data bits LSB first, optional
// even parity bit, stop bit (1). Each bit lasts CLKS_PER_BIT clock cycles.
//
// Optional feature (compile-time macro FIFO_UART_TX_PARITY_EN):
//   defined     -> an even-parity bit is sent between the data and stop bits.
//   not defined -> no parity state and no parity logic.
//
// Parameters:
//   CLKS_PER_BIT  clock cycles per serial bit (2..65535)
//   DATA_W        byte width, equal to the fifo data width
//
// Ports:
//   clk         in   system clock, all logic on the rising edge
//   reset       in   synchronous, active-high reset
//   tx_en       in   1 = new frames may start; 0 = finish current frame only
//   fifo_empty  in   fifo empty flag
//   fifo_data   in   fifo read data, valid the cycle after fifo_rd
//   fifo_rd     out  fifo read strobe, one registered cycle per byte
//   tx          out  serial line, idles high
//   busy        out  high from the pop request to the end of the stop bit
//   frame_done  out  one-cycle pulse after each completed stop bit
// ---------------------------------------------------------------------------
module fifo_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_W       = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              tx_en,
    input  logic              fifo_empty,
    input  logic [DATA_W-1:0] fifo_data,
    output logic              fifo_rd,
    output logic              tx,
    output logic              busy,
    output logic              frame_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int IDX_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(DATA_W - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_POP,
        S_LOAD,
        S_START,
        S_DATA,
        S_STOP
`ifdef FIFO_UART_TX_PARITY_EN
        , S_PARITY
`endif
    } state_t;

    state_t            r_state;
    logic [CNT_W-1:0]  r_cnt;
    logic [IDX_W-1:0]  r_idx;
    logic [DATA_W-1:0] r_shift;
    logic              r_tx;
    logic              r_rd;
    logic              r_busy;
    logic              r_done;

    state_t            w_state;
    logic [CNT_W-1:0]  w_cnt;
    logic [IDX_W-1:0]  w_idx;
    logic [DATA_W-1:0] w_shift;
    logic              w_tx;
    logic              w_rd;
    logic              w_busy;
    logic              w_done;
    logic              w_bit_last;

    assign w_bit_last = (r_cnt == CNT_LAST);

`ifdef FIFO_UART_TX_PARITY_EN
    logic w_parity;
    assign w_parity = ^r_shift;
`endif

    // State and output registers. tx returns high immediately on reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
            r_rd    <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state;
            r_cnt   <= w_cnt;
            r_idx   <= w_idx;
            r_shift <= w_shift;
            r_tx    <= w_tx;
            r_rd    <= w_rd;
            r_busy  <= w_busy;
            r_done  <= w_done;
        end
    end

    // Next-state and next-output logic. fifo_rd and frame_done are strobes,
    // so they default to 0; everything else holds unless a state changes it.
    always_comb begin
        w_state = r_state;
        w_cnt   = r_cnt;
        w_idx   = r_idx;
        w_shift = r_shift;
        w_tx    = r_tx;
        w_rd    = 1'b0;
        w_busy  = r_busy;
        w_done  = 1'b0;

        case (r_state)
            S_IDLE: begin
                // tx_en and fifo_empty are only looked at here, so a single
                // pop per frame is guaranteed and the fifo is never overread.
                w_tx = 1'b1;
                if (tx_en && !fifo_empty) begin
                    w_rd    = 1'b1;
                    w_busy  = 1'b1;
                    w_state = S_POP;
                end
            end

            S_POP: begin
                // The fifo samples the read strobe on this edge; its data
                // appears on fifo_data during LOAD.
                w_state = S_LOAD;
            end

            S_LOAD: begin
                w_shift = fifo_data;
                w_tx    = 1'b0;
                w_cnt   = '0;
                w_state = S_START;
            end

            S_START: begin
                if (w_bit_last) begin
                    w_cnt   = '0;
                    w_idx   = '0;
                    w_tx    = r_shift[0];
                    w_state = S_DATA;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            S_DATA: begin
                if (w_bit_last) begin
                    w_cnt = '0;
                    if (r_idx == IDX_LAST) begin
                        w_idx = '0;
`ifdef FIFO_UART_TX_PARITY_EN
                        w_tx    = w_parity;
                        w_state = S_PARITY;
`else
                        w_tx    = 1'b1;
                        w_state = S_STOP;
`endif
                    end else begin
                        w_idx = r_idx + IDX_W'(1);
                        w_tx  = r_shift[w_idx];
                    end
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

`ifdef FIFO_UART_TX_PARITY_EN
            S_PARITY: begin
                if (w_bit_last) begin
                    w_cnt   = '0;
                    w_tx    = 1'b1;
                    w_state = S_STOP;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end
`endif

            S_STOP: begin
                w_tx = 1'b1;
                if (w_bit_last) begin
                    w_cnt   = '0;
                    w_busy  = 1'b0;
                    w_done  = 1'b1;
                    w_state = S_IDLE;
                end else begin
                    w_cnt = r_cnt + CNT_W'(1);
                end
            end

            default: begin
                w_tx    = 1'b1;
                w_busy  = 1'b0;
                w_state = S_IDLE;
            end
        endcase
    end

    assign fifo_rd    = r_rd;
    assign tx         = r_tx;
    assign busy       = r_busy;
    assign frame_done = r_done;

endmodule
